regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read/multi-write register file for the decode stage. It generalises the 2-read/1-write bank with configurable port counts and a hardwired-zero R0. Same-cycle write-to-read forwarding is selectable. A handshaked dump engine streams every register to the debug unit for inspection over the serial link.

Parameters:
NB_REG, 5, register address width
NB_DATA, 32, data width
N_REGISTER, 32, number of registers (≤ 2**NB_REG)
N_RD, 2, read ports (1..4)
N_WR, 1, write ports (1..2)

Ports:
i_clock  in  1  clock, all logic on posedge
i_reset  in  1  synchronous, active-high reset
i_rd_addr  in  N_RD*NB_REG  read addresses; port k at [k*NB_REG +: NB_REG]
o_rd_data  out  N_RD*NB_DATA  read data; port k at [k*NB_DATA +: NB_DATA]
i_wr_en  in  N_WR  per-port write enable
i_wr_addr  in  N_WR*NB_REG  write addresses, same packing
i_wr_data  in  N_WR*NB_DATA  write data, same packing
i_dump_start  in  1  start dump (accepted only in IDLE)
i_dump_ready  in  1  consumer ready
o_dump_valid  out  1  o_dump_data/o_dump_idx valid
o_dump_data  out  NB_DATA  dumped register value
o_dump_idx  out  NB_REG  index of dumped register
o_dump_busy  out  1  high in LOAD/SEND/DONE
o_dump_done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (i_reset high at posedge): all registers, o_rd_data, o_dump_data and o_dump_idx go to 0. o_dump_valid, o_dump_busy and o_dump_done go to 0. FSM goes to IDLE. Reset mid-dump aborts with no done pulse. Reset overrides same-cycle writes and start.
- Write: at posedge, if i_wr_en[j] is high and i_wr_addr[j] is nonzero and < N_REGISTER, the register takes i_wr_data[j]. Writes to R0 or out-of-range addresses are ignored.
- Write collision on the same address: the higher port index wins.
- Read: registered, 1-cycle latency. Sampled at posedge t, visible after t.
- R0 always reads 0. Out-of-range read addresses return 0.
- Read/write same cycle: see RF_BYPASS_EN.
- Dump FSM states and transitions:
  - IDLE: i_dump_start=1 → idx=0, go to LOAD.
  - LOAD: o_dump_data = stored array[idx] (pre-write value of this edge), o_dump_idx = idx, o_dump_valid = 1, go to SEND.
  - SEND: hold data and valid while i_dump_ready=0. On i_dump_ready=1: valid drops; if idx == N_REGISTER-1 go to DONE, else idx+1 and go to LOAD.
  - DONE: o_dump_done=1 for one cycle, then IDLE.
- Dump throughput: at most 1 word per 2 cycles.
- Start while busy is ignored.
- Normal reads and writes continue during a dump. A register written before its LOAD cycle is dumped with its new value.

Optional Feature:
RF_BYPASS_EN
- Defined: write-first. A read whose address matches an enabled same-cycle write (nonzero address) returns the write data; on multiple matches, the highest write port's data.
- Undefined: read-first. The read returns the pre-write contents; the new value is visible from the next read.
- The dump path never bypasses in either mode.

Test Plan:
- Reset, then read all addresses → o_rd_data all 0; o_dump_valid=0, o_dump_busy=0.
- Write R5=0xDEADBEEF; next cycle read R5 on both ports → 0xDEADBEEF on both ports one cycle later.
- Write R0=0xFFFFFFFF, then read R0 → 0.
- Same-cycle write R7=0x11 while reading R7 (R7 previously 0x22) → 0x11 with RF_BYPASS_EN, 0x22 without.
- N_WR=2: both ports write R3 (0xA on port 0, 0xB on port 1) → R3=0xB.
- Preload Rn=n+0x100, pulse start, i_dump_ready toggling 1/0 → 32 words in order, idx 0..31, data 0 then 0x101..0x11F, each held while ready=0; single done pulse. Assert i_reset at word 10 → valid/busy 0 next cycle, no done pulse.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero R0, registered reads and a handshaked dump engine.
// Optional macro RF_BYPASS_EN selects write-first reads; undefined gives read-first reads.
module regfile_mp #(
  parameter int NB_REG     = 5,
  parameter int NB_DATA    = 32,
  parameter int N_REGISTER = 32,
  parameter int N_RD       = 2,
  parameter int N_WR       = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [N_RD*NB_REG-1:0]    i_rd_addr,
  output logic [N_RD*NB_DATA-1:0]   o_rd_data,
  input  logic [N_WR-1:0]           i_wr_en,
  input  logic [N_WR*NB_REG-1:0]    i_wr_addr,
  input  logic [N_WR*NB_DATA-1:0]   i_wr_data,
  input  logic                      i_dump_start,
  input  logic                      i_dump_ready,
  output logic                      o_dump_valid,
  output logic [NB_DATA-1:0]        o_dump_data,
  output logic [NB_REG-1:0]         o_dump_idx,
  output logic                      o_dump_busy,
  output logic                      o_dump_done
);

  typedef logic [NB_DATA-1:0] word_t;
  typedef logic [NB_REG-1:0]  addr_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} dump_state_e;

  localparam logic [NB_REG:0] N_REG_W  = (NB_REG+1)'(N_REGISTER);
  localparam addr_t           LAST_IDX = NB_REG'(N_REGISTER - 1);

  // R0 and addresses beyond the array are never stored and always read as zero.
  function automatic logic addr_ok(input addr_t a);
    return (a != '0) && ({1'b0, a} < N_REG_W);
  endfunction

  word_t regs_q [N_REGISTER];
  word_t regs_d [N_REGISTER];
  word_t rd_q   [N_RD];
  word_t rd_d   [N_RD];

  addr_t           wr_addr [N_WR];
  word_t           wr_data [N_WR];
  logic [N_WR-1:0] wr_ok;
  addr_t           rd_addr [N_RD];

  for (genvar j = 0; j < N_WR; j++) begin : g_wr
    assign wr_addr[j] = i_wr_addr[j*NB_REG +: NB_REG];
    assign wr_data[j] = i_wr_data[j*NB_DATA +: NB_DATA];
    assign wr_ok[j]   = i_wr_en[j] && addr_ok(wr_addr[j]);
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    assign rd_addr[k]                     = i_rd_addr[k*NB_REG +: NB_REG];
    assign o_rd_data[k*NB_DATA +: NB_DATA] = rd_q[k];
  end

  // Ascending port order makes the highest-indexed writer win a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < N_WR; j++) begin
      if (wr_ok[j]) regs_d[wr_addr[j]] = wr_data[j];
    end
  end

  // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      rd_d[k] = '0;
      if (addr_ok(rd_addr[k])) begin
        rd_d[k] = regs_q[rd_addr[k]];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < N_WR; j++) begin
          if (wr_ok[j] && (wr_addr[j] == rd_addr[k])) rd_d[k] = wr_data[j];
        end
`endif
      end
    end
  end

  // NOTE: the array is reset because software expects a clean all-zero bank after reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGISTER; i++) regs_q[i] <= '0;
      for (int k = 0; k < N_RD; k++)       rd_q[k]   <= '0;
    end else begin
      regs_q <= regs_d;
      rd_q   <= rd_d;
    end
  end

  dump_state_e state_q, state_d;
  addr_t       idx_q, idx_d;
  addr_t       dump_idx_q, dump_idx_d;
  word_t       dump_data_q, dump_data_d;
  logic        dump_valid_q, dump_valid_d;

  // The dump samples the stored array, never the bypass path.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = dump_valid_q;
    case (state_q)
      S_IDLE: begin
        if (i_dump_start) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dump_data_d  = regs_q[idx_q];
        dump_idx_d   = idx_q;
        dump_valid_d = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        if (i_dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign o_dump_valid = dump_valid_q;
  assign o_dump_data  = dump_data_q;
  assign o_dump_idx   = dump_idx_q;
  assign o_dump_busy  = (state_q != S_IDLE);
  assign o_dump_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (two write ports): reset, reads/writes, R0, collisions,
// forwarding mode and the dump engine including a mid-dump reset.
module tb_regfile_mp;
  localparam int NB_REG     = 5;
  localparam int NB_DATA    = 32;
  localparam int N_REGISTER = 32;
  localparam int N_RD       = 2;
  localparam int N_WR       = 2;

  logic                     i_clock = 1'b0;
  logic                     i_reset;
  logic [N_RD*NB_REG-1:0]   i_rd_addr;
  logic [N_RD*NB_DATA-1:0]  o_rd_data;
  logic [N_WR-1:0]          i_wr_en;
  logic [N_WR*NB_REG-1:0]   i_wr_addr;
  logic [N_WR*NB_DATA-1:0]  i_wr_data;
  logic                     i_dump_start;
  logic                     i_dump_ready;
  logic                     o_dump_valid;
  logic [NB_DATA-1:0]       o_dump_data;
  logic [NB_REG-1:0]        o_dump_idx;
  logic                     o_dump_busy;
  logic                     o_dump_done;

  always #5 i_clock = ~i_clock;

  regfile_mp #(
    .NB_REG(NB_REG), .NB_DATA(NB_DATA), .N_REGISTER(N_REGISTER), .N_RD(N_RD), .N_WR(N_WR)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .o_dump_idx(o_dump_idx),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [NB_REG-1:0] a,
                        input logic [NB_DATA-1:0] d);
    i_wr_en[j]                       = en;
    i_wr_addr[j*NB_REG +: NB_REG]    = a;
    i_wr_data[j*NB_DATA +: NB_DATA]  = d;
  endtask

  task automatic set_rd(input int k, input logic [NB_REG-1:0] a);
    i_rd_addr[k*NB_REG +: NB_REG] = a;
  endtask

  function automatic logic [NB_DATA-1:0] rd_port(input int k);
    return o_rd_data[k*NB_DATA +: NB_DATA];
  endfunction

  // Expected dump contents after preload and the in-flight rewrite of R20.
  function automatic logic [NB_DATA-1:0] exp_dump(input int n);
    if (n == 0)  return '0;
    if (n == 20) return 32'h555;
    return 32'h100 + NB_DATA'(n);
  endfunction

  initial begin
    int w;
    int done_cnt;
    logic hit;

    i_reset = 1'b1; i_rd_addr = '0; i_wr_en = '0; i_wr_addr = '0; i_wr_data = '0;
    i_dump_start = 1'b0; i_dump_ready = 1'b0;
    step(); step();
    i_reset = 1'b0;
    check("rst_rd0", rd_port(0), 0);
    check("rst_rd1", rd_port(1), 0);
    check("rst_valid", o_dump_valid, 0);
    check("rst_busy", o_dump_busy, 0);
    check("rst_done", o_dump_done, 0);
    check("rst_ddata", o_dump_data, 0);

    for (int a = 0; a < N_REGISTER; a++) begin
      set_rd(0, NB_REG'(a)); set_rd(1, NB_REG'(N_REGISTER - 1 - a));
      step();
      check("rst_all_rd0", rd_port(0), 0);
      check("rst_all_rd1", rd_port(1), 0);
    end

    set_wr(0, 1, 5, 32'hDEADBEEF);
    step();
    set_wr(0, 0, 0, 0); set_rd(0, 5); set_rd(1, 5);
    step();
    check("r5_rd0", rd_port(0), 32'hDEADBEEF);
    check("r5_rd1", rd_port(1), 32'hDEADBEEF);

    set_wr(0, 1, 0, 32'hFFFFFFFF);
    step();
    set_wr(0, 0, 0, 0); set_rd(0, 0); set_rd(1, 0);
    step();
    check("r0_rd0", rd_port(0), 0);
    check("r0_rd1", rd_port(1), 0);

    set_wr(0, 1, 7, 32'h22);
    step();
    set_wr(0, 1, 7, 32'h11); set_rd(0, 7); set_rd(1, 7);
    step();
`ifdef RF_BYPASS_EN
    check("fwd_r7", rd_port(0), 32'h11);
`else
    check("fwd_r7", rd_port(0), 32'h22);
`endif
    set_wr(0, 0, 0, 0);
    step();
    check("r7_after", rd_port(1), 32'h11);

    set_wr(0, 1, 3, 32'hA); set_wr(1, 1, 3, 32'hB);
    step();
    set_wr(0, 0, 0, 0); set_wr(1, 0, 0, 0); set_rd(0, 3); set_rd(1, 3);
    step();
    check("coll_r3", rd_port(0), 32'hB);

    set_wr(0, 1, 3, 32'hC); set_wr(1, 1, 3, 32'hD);
    step();
`ifdef RF_BYPASS_EN
    check("coll_fwd_r3", rd_port(1), 32'hD);
`else
    check("coll_fwd_r3", rd_port(1), 32'hB);
`endif
    set_wr(0, 0, 0, 0); set_wr(1, 1, 0, 32'hFFFFFFFF); set_rd(0, 0);
    step();
    check("r0_no_fwd", rd_port(0), 0);
    set_wr(1, 0, 0, 0);

    for (int n = 1; n < N_REGISTER; n++) begin
      set_wr(0, 1, NB_REG'(n), 32'h100 + NB_DATA'(n));
      step();
    end
    set_wr(0, 0, 0, 0);
    set_rd(0, 20);

    // Dump with ready toggling 1/0 and R20 rewritten before its LOAD.
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    check("dump_busy_start", o_dump_busy, 1);
    w = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 400 && !(w == N_REGISTER && !o_dump_busy); cyc++) begin
      i_dump_ready = (cyc % 2 == 0);
      if (w == 5) set_wr(0, 1, 20, 32'h555);
      else        set_wr(0, 0, 0, 0);
      if (o_dump_done) done_cnt++;
      if (o_dump_valid) begin
        check("dump_idx", 64'(o_dump_idx), 64'(w));
        check("dump_data", o_dump_data, exp_dump(w));
        if (i_dump_ready) w++;
      end
      step();
    end
    set_wr(0, 0, 0, 0);
    check("dump_words", 64'(w), 64'(N_REGISTER));
    check("dump_done_cnt", 64'(done_cnt), 1);
    check("dump_idle_busy", o_dump_busy, 0);
    check("dump_idle_valid", o_dump_valid, 0);
    check("rd_during_dump", rd_port(0), 32'h555);

    // Second dump with start held high (ignored while busy), aborted by reset at word 10.
    i_dump_start = 1'b1;
    w = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      i_dump_ready = (cyc % 2 == 0);
      check("dump2_no_done", o_dump_done, 0);
      if (o_dump_valid) begin
        check("dump2_idx", 64'(o_dump_idx), 64'(w));
        check("dump2_data", o_dump_data, exp_dump(w));
        if (w == 10)          hit = 1'b1;
        else if (i_dump_ready) w++;
      end
      if (!hit) step();
    end
    check("dump2_reached_w10", hit, 1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0; i_dump_start = 1'b0;
    check("abort_valid", o_dump_valid, 0);
    check("abort_busy", o_dump_busy, 0);
    check("abort_done", o_dump_done, 0);
    check("abort_ddata", o_dump_data, 0);
    check("abort_didx", o_dump_idx, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_no_done", o_dump_done, 0);
      check("abort_rd_cleared", rd_port(0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
